// File: rtl/writeback_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// wb_ctrl_pkg
// Shared encodings for the register-file writeback sequencer:
//   - writeback class codes handed over by main control
//   - write-register and write-data mux selector values
//   - FSM state encoding and the write-phase tag used by the selector decode
// ---------------------------------------------------------------------------
package wb_ctrl_pkg;

  typedef enum logic [2:0] {
    WB_NONE    = 3'd0,
    WB_RT_ALU  = 3'd1,
    WB_RD_ALU  = 3'd2,
    WB_LINK    = 3'd3,
    WB_RT_MEM  = 3'd4,
    WB_POP     = 3'd5,
    WB_PUSH    = 3'd6,
    WB_LINK_RD = 3'd7
  } wb_class_e;

  // write-register mux
  localparam logic [3:0] SEL_RT = 4'd0;
  localparam logic [3:0] SEL_RD = 4'd1;
  localparam logic [3:0] SEL_RA = 4'd2;
  localparam logic [3:0] SEL_SP = 4'd3;

  // write-data mux
  localparam logic [2:0] D_ALU   = 3'd0;
  localparam logic [2:0] D_MDR   = 3'd1;
  localparam logic [2:0] D_PC    = 3'd2;
  localparam logic [2:0] D_SPINC = 3'd3;
  localparam logic [2:0] D_SPDEC = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_MEM = 3'd1,
    S_WRITE1   = 3'd2,
    S_WRITE2   = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } state_e;

  // which write cycle (if any) the selector decode should produce
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_WRITE1 = 2'd1,
    PH_WRITE2 = 2'd2
  } phase_e;

  function automatic logic needs_mem(wb_class_e cls);
    return (cls == WB_RT_MEM) || (cls == WB_POP);
  endfunction

endpackage

// File: rtl/writeback_ctrl_if.sv
// ---------------------------------------------------------------------------
// wb_ctrl_if
// Handshake bundle between main control / memory and the writeback sequencer.
//   start, wb_class : request from main control
//   mem_ready       : memory read data valid
//   wr_reg_sel, wr_data_sel, reg_write, mdr_load : datapath controls
//   busy, done, mem_err : status back to main control
// master = main control side, slave = writeback_ctrl.
// ---------------------------------------------------------------------------
interface wb_ctrl_if;
  logic       start;
  logic [2:0] wb_class;
  logic       mem_ready;
  logic [3:0] wr_reg_sel;
  logic [2:0] wr_data_sel;
  logic       reg_write;
  logic       mdr_load;
  logic       busy;
  logic       done;
  logic       mem_err;

  modport master (
    output start, wb_class, mem_ready,
    input  wr_reg_sel, wr_data_sel, reg_write, mdr_load, busy, done, mem_err
  );

  modport slave (
    input  start, wb_class, mem_ready,
    output wr_reg_sel, wr_data_sel, reg_write, mdr_load, busy, done, mem_err
  );
endinterface

// File: rtl/writeback_ctrl_sel_decode.sv
// ---------------------------------------------------------------------------
// wb_sel_decode
// Combinational selector decode for the writeback stage.
//   i_cls        : latched writeback class
//   i_phase      : current write phase (none / first / second write)
//   o_reg_sel    : write-register mux selector
//   o_data_sel   : write-data mux selector
// Both selectors are 0 whenever no write is in progress.
// ---------------------------------------------------------------------------
module wb_sel_decode
  import wb_ctrl_pkg::*;
(
  input  wb_class_e  i_cls,
  input  phase_e     i_phase,
  output logic [3:0] o_reg_sel,
  output logic [2:0] o_data_sel
);

  always_comb begin
    o_reg_sel  = SEL_RT;
    o_data_sel = D_ALU;
    case (i_phase)
      PH_WRITE1: begin
        case (i_cls)
          WB_RT_ALU:  begin o_reg_sel = SEL_RT; o_data_sel = D_ALU;   end
          WB_RD_ALU:  begin o_reg_sel = SEL_RD; o_data_sel = D_ALU;   end
          WB_LINK:    begin o_reg_sel = SEL_RA; o_data_sel = D_PC;    end
          WB_RT_MEM:  begin o_reg_sel = SEL_RT; o_data_sel = D_MDR;   end
          WB_POP:     begin o_reg_sel = SEL_RT; o_data_sel = D_MDR;   end
          WB_PUSH:    begin o_reg_sel = SEL_SP; o_data_sel = D_SPDEC; end
          WB_LINK_RD: begin o_reg_sel = SEL_RD; o_data_sel = D_PC;    end
          default:    begin o_reg_sel = SEL_RT; o_data_sel = D_ALU;   end
        endcase
      end
      // second write only exists for POP: stack pointer bump
      PH_WRITE2: begin
        o_reg_sel  = SEL_SP;
        o_data_sel = D_SPINC;
      end
      default: begin
        o_reg_sel  = SEL_RT;
        o_data_sel = D_ALU;
      end
    endcase
  end

endmodule

// File: rtl/writeback_ctrl.sv
// ---------------------------------------------------------------------------
// writeback_ctrl
// Register-file writeback sequencer. Accepts one writeback class per
// instruction, waits for memory data when needed, drives one or two write
// cycles and reports completion (done) or memory timeout (mem_err).
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; forces IDLE
//   wb    : wb_ctrl_if.slave handshake / datapath control bundle
// Parameter MEM_TIMEOUT (1..255): WAIT_MEM cycles allowed without mem_ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; samples wb_class
// WAIT_MEM | waiting for mem_ready; mdr_load follows mem_ready
// WRITE1   | first register write, selectors from latched class
// WRITE2   | POP only: $29 <= SP+4
// DONE     | one-cycle done pulse
// ERR      | one-cycle mem_err pulse, no write happened
// ---------------------------------------------------------------------------
module writeback_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  wb_ctrl_if.slave    wb
);

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     r_state;
  wb_class_e  r_cls;
  logic [7:0] r_cnt;

  state_e     w_next;
  wb_class_e  w_cls_next;
  logic [7:0] w_cnt_next;
  phase_e     w_phase;
  logic       w_reg_write;
  logic       w_mdr_load;
  logic       w_busy;
  logic       w_done;
  logic       w_mem_err;
  logic [3:0] w_reg_sel;
  logic [2:0] w_data_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cls   <= WB_NONE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cls   <= w_cls_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cls_next  = r_cls;
    w_cnt_next  = r_cnt;
    w_phase     = PH_IDLE;
    w_reg_write = 1'b0;
    w_mdr_load  = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_mem_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (wb.start) begin
          w_cls_next = wb_class_e'(wb.wb_class);
          if (wb_class_e'(wb.wb_class) == WB_NONE) begin
            w_next = S_DONE;
          end else if (needs_mem(wb_class_e'(wb.wb_class))) begin
            w_next     = S_WAIT_MEM;
            w_cnt_next = '0;
          end else begin
            w_next = S_WRITE1;
          end
        end
      end
      S_WAIT_MEM: begin
        // the only input-to-output path: MDR captures the data in the
        // same cycle memory presents it
        w_mdr_load = wb.mem_ready;
        if (wb.mem_ready) begin
          w_next = S_WRITE1;
        end else if (r_cnt == CNT_LAST) begin
          w_next = S_ERR;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_WRITE1: begin
        w_phase     = PH_WRITE1;
        w_reg_write = 1'b1;
        w_next      = (r_cls == WB_POP) ? S_WRITE2 : S_DONE;
      end
      S_WRITE2: begin
        w_phase     = PH_WRITE2;
        w_reg_write = 1'b1;
        w_next      = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        w_mem_err = 1'b1;
        w_next    = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  wb_sel_decode u_sel_decode (
    .i_cls      (r_cls),
    .i_phase    (w_phase),
    .o_reg_sel  (w_reg_sel),
    .o_data_sel (w_data_sel)
  );

  assign wb.wr_reg_sel  = w_reg_sel;
  assign wb.wr_data_sel = w_data_sel;
  assign wb.reg_write   = w_reg_write;
  assign wb.mdr_load    = w_mdr_load;
  assign wb.busy        = w_busy;
  assign wb.done        = w_done;
  assign wb.mem_err     = w_mem_err;

endmodule

// File: tb/tb_writeback_ctrl.sv
module tb_writeback_ctrl;
  import wb_ctrl_pkg::*;

  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic       rw;
    logic [3:0] rs;
    logic [2:0] ds;
    logic       ml;
    logic       busy;
    logic       done;
    logic       err;
  } out_t;

  typedef struct {
    wb_class_e  cls;
    int         ready_at;   // WAIT_MEM cycle with mem_ready=1, 0 = never
    logic [3:0] r1;
    logic [2:0] d1;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  string cur_name = "reset";
  out_t exp_q[$];
  vec_t vecs[13];

  wb_ctrl_if bus ();

  writeback_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(logic rw, logic [3:0] rs, logic [2:0] ds,
                              logic ml, logic busy, logic done, logic err);
    out_t o;
    o.rw = rw; o.rs = rs; o.ds = ds; o.ml = ml;
    o.busy = busy; o.done = done; o.err = err;
    return o;
  endfunction

  function automatic out_t get_out();
    return mk(bus.reg_write, bus.wr_reg_sel, bus.wr_data_sel, bus.mdr_load,
              bus.busy, bus.done, bus.mem_err);
  endfunction

  task automatic chk(string name, out_t got, out_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got rw=%0b rs=%0d ds=%0d ml=%0b busy=%0b done=%0b err=%0b, want rw=%0b rs=%0d ds=%0d ml=%0b busy=%0b done=%0b err=%0b",
               name, got.rw, got.rs, got.ds, got.ml, got.busy, got.done, got.err,
               want.rw, want.rs, want.ds, want.ml, want.busy, want.done, want.err);
    end
  endtask

  // scoreboard: one expected record per cycle, compared at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e;
      e = exp_q.pop_front();
      chk(cur_name, get_out(), e);
    end
  end

  function automatic void push_idle();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
  endfunction

  // expected cycles 1..N of one accepted request
  function automatic void push_exp(vec_t v);
    case (v.cls)
      WB_NONE: exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0));
      WB_RT_MEM, WB_POP: begin
        if (v.ready_at == 0) begin
          for (int i = 1; i <= TIMEOUT; i++) exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
          exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 1));
        end else begin
          for (int i = 1; i < v.ready_at; i++) exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
          exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0));
          exp_q.push_back(mk(1, v.r1, v.d1, 0, 1, 0, 0));
          if (v.cls == WB_POP) exp_q.push_back(mk(1, 4'd3, 3'd3, 0, 1, 0, 0));
          exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        end
      end
      default: begin
        exp_q.push_back(mk(1, v.r1, v.d1, 0, 1, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0));
      end
    endcase
  endfunction

  task automatic drain();
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s drain: %0d expected cycles left, want 0", cur_name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_txn(vec_t v, string name);
    int n;
    @(posedge clk); #1;
    cur_name = name;
    bus.start = 1'b1;
    bus.wb_class = v.cls;
    bus.mem_ready = 1'b0;
    push_idle();
    push_exp(v);
    push_idle();
    n = exp_q.size() - 1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.wb_class = WB_NONE;
      bus.mem_ready = (c == v.ready_at);
    end
    drain();
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vl, vp;
    vecs[0]  = '{cls: WB_RT_ALU,  ready_at: 0, r1: SEL_RT, d1: D_ALU};
    vecs[1]  = '{cls: WB_RD_ALU,  ready_at: 0, r1: SEL_RD, d1: D_ALU};
    vecs[2]  = '{cls: WB_LINK,    ready_at: 0, r1: SEL_RA, d1: D_PC};
    vecs[3]  = '{cls: WB_PUSH,    ready_at: 0, r1: SEL_SP, d1: D_SPDEC};
    vecs[4]  = '{cls: WB_LINK_RD, ready_at: 0, r1: SEL_RD, d1: D_PC};
    vecs[5]  = '{cls: WB_NONE,    ready_at: 0, r1: SEL_RT, d1: D_ALU};
    vecs[6]  = '{cls: WB_RT_MEM,  ready_at: 1, r1: SEL_RT, d1: D_MDR};
    vecs[7]  = '{cls: WB_RT_MEM,  ready_at: 2, r1: SEL_RT, d1: D_MDR};
    vecs[8]  = '{cls: WB_POP,     ready_at: 3, r1: SEL_RT, d1: D_MDR};
    vecs[9]  = '{cls: WB_RT_MEM,  ready_at: 0, r1: SEL_RT, d1: D_MDR};
    vecs[10] = '{cls: WB_RT_MEM,  ready_at: 4, r1: SEL_RT, d1: D_MDR};
    vecs[11] = '{cls: WB_POP,     ready_at: 0, r1: SEL_RT, d1: D_MDR};
    vecs[12] = '{cls: WB_POP,     ready_at: 1, r1: SEL_RT, d1: D_MDR};

    bus.start = 1'b0;
    bus.wb_class = WB_NONE;
    bus.mem_ready = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", get_out(), mk(0, 0, 0, 0, 0, 0, 0));
    #1 reset = 1'b0;

    for (int i = 0; i < 13; i++) run_txn(vecs[i], $sformatf("vec%0d_cls%0d", i, vecs[i].cls));

    // asynchronous reset in the middle of a POP's first write
    cur_name = "reset_mid_pop";
    @(posedge clk); #1;
    bus.start = 1'b1; bus.wb_class = WB_POP; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.wb_class = WB_NONE; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("pop_write1_before_reset", get_out(), mk(1, SEL_RT, D_MDR, 0, 1, 0, 0));
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", get_out(), mk(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #3;
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", get_out(), mk(0, 0, 0, 0, 0, 0, 0));
    run_txn(vecs[0], "rt_alu_after_reset");

    // start held high: LINK accepted, PUSH ignored until IDLE
    @(posedge clk); #1;
    cur_name = "link_then_push";
    bus.start = 1'b1; bus.wb_class = WB_LINK; bus.mem_ready = 1'b0;
    vl = '{cls: WB_LINK, ready_at: 0, r1: SEL_RA, d1: D_PC};
    vp = '{cls: WB_PUSH, ready_at: 0, r1: SEL_SP, d1: D_SPDEC};
    push_idle();
    push_exp(vl);
    push_idle();
    push_exp(vp);
    push_idle();
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      bus.start = (c <= 3);
      bus.wb_class = WB_PUSH;
    end
    drain();
    bus.start = 1'b0;
    bus.wb_class = WB_NONE;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
